// File: rtl/demux_1_4_stream.sv
// Purpose : 1-to-4 stream demux; one beat per cycle is steered to a lane chosen by in_sel or a round-robin pointer.
// Latency : one cycle from accept to the beat appearing on its lane's one-entry holding register.
// Backpres: in_ready reflects only the target lane (free when empty or draining this cycle); other lanes never stall input.
module demux_1_4_stream #(
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [1:0]           rr_ptr
);

    logic [3:0]            r_valid;
    logic [3:0][WIDTH-1:0] r_data;
    logic [1:0]            r_rr_ptr;

    logic [1:0]            w_tgt;
    logic [3:0]            w_lane_free;
    logic                  w_accept;

    // In round-robin mode in_sel is ignored entirely; the pointer alone picks the lane (no skipping of full lanes).
    assign w_tgt       = (RR_MODE != 0) ? r_rr_ptr : in_sel;

    // A lane can take a new beat if it is empty or its current beat leaves this same cycle.
    assign w_lane_free = ~r_valid | out_ready;

    // Combinational out_ready -> in_ready path is intentional: it lets a draining lane reload with no bubble.
    assign in_ready    = w_lane_free[w_tgt];
    assign w_accept    = in_valid && in_ready;

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign rr_ptr      = r_rr_ptr;

    // Per-lane holding registers and the round-robin pointer; reset overrides any load or drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_accept && (w_tgt == 2'(k))) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    // Data is left in place after a drain; only the valid flag drops.
                    r_valid[k] <= 1'b0;
                end
            end
            // Pointer counts accepted beats mod 4 in both modes, so it doubles as a beat index.
            if (w_accept) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: instance 0 uses explicit select, instance 1 uses round-robin.
// A queue-based scoreboard checks every cycle; directed sections pin literal values.
module tb_demux_1_4_stream;

    logic        clk;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  in_data   [2];
    logic [1:0]  in_sel    [2];
    logic [3:0]  out_valid [2];
    logic [3:0]  out_ready [2];
    logic [31:0] out_data  [2];
    logic [1:0]  rr_ptr    [2];

    int n_pass  = 0;
    int n_total = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        demux_1_4_stream #(.WIDTH(8), .RR_MODE(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_sel    (in_sel[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .rr_ptr    (rr_ptr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each lane is a queue of accepted-but-undelivered beats; the lane's visible data is the
    // last beat ever written to it (zero after reset); rr_ptr is the accept count mod 4.
    logic [7:0] m_q    [2][4][$];
    logic [7:0] m_last [2][4];
    int         m_acc  [2];
    bit         m_init = 1'b0;
    logic [1:0] m_t;
    bit         m_rdy;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_init) begin
                for (int k = 0; k < 4; k++) begin
                    check("lane_valid", 32'(out_valid[i][k]), 32'(m_q[i][k].size() != 0));
                    check("lane_data", 32'(out_data[i][k*8 +: 8]), 32'(m_last[i][k]));
                end
                check("rr_ptr", 32'(rr_ptr[i]), 32'(m_acc[i] % 4));
            end
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    m_q[i][k].delete();
                    m_last[i][k] = 8'h00;
                end
                m_acc[i] = 0;
                m_init   = 1'b1;
            end else if (m_init) begin
                m_t   = (i == 1) ? 2'(m_acc[i] % 4) : in_sel[i];
                m_rdy = (m_q[i][m_t].size() == 0) || out_ready[i][m_t];
                check("in_ready", 32'(in_ready[i]), 32'(m_rdy));
                for (int k = 0; k < 4; k++) begin
                    if (m_q[i][k].size() != 0 && out_ready[i][k]) begin
                        check("delivery", 32'(out_data[i][k*8 +: 8]), 32'(m_q[i][k][0]));
                        void'(m_q[i][k].pop_front());
                    end
                end
                if (in_valid[i] && m_rdy) begin
                    m_q[i][m_t].push_back(in_data[i]);
                    m_last[i][m_t] = in_data[i];
                    m_acc[i]++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d, input logic [1:0] s);
        in_valid[i] = v;
        in_data[i]  = d;
        in_sel[i]   = s;
    endtask

    logic [7:0] steer_dat [4];

    initial begin
        steer_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b1, 8'hAA, 2'd0);
            out_ready[i] = 4'b0000;
        end

        // Reset clear: two reset edges with a live input beat, nothing may load.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 8'h00, 2'd0);
            out_ready[i] = 4'b1111;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", 32'(out_valid[i]), 32'h0);
            check("rst_data", out_data[i], 32'h0);
            check("rst_rr", 32'(rr_ptr[i]), 32'h0);
        end

        // Explicit steering on instance 0.
        tick();
        for (int j = 0; j < 4; j++) begin
            drive(0, 1'b1, steer_dat[j], 2'(j));
            @(negedge clk);
            check("steer_rdy", 32'(in_ready[0]), 32'h1);
            if (j > 0) begin
                check("steer_vld", 32'(out_valid[0]), 32'(4'b0001 << (j - 1)));
                check("steer_dat", 32'(out_data[0][(j-1)*8 +: 8]), 32'(steer_dat[j-1]));
            end
            tick();
        end
        drive(0, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        check("steer_vld3", 32'(out_valid[0]), 32'h8);
        check("steer_dat3", 32'(out_data[0][31:24]), 32'h44);
        check("steer_rr", 32'(rr_ptr[0]), 32'h0);
        tick();

        // Backpressure on lane 2 of instance 0, with a concurrent lane-1 beat.
        out_ready[0] = 4'b1011;
        drive(0, 1'b1, 8'h5A, 2'd2);
        @(negedge clk);
        check("bp_rdy1", 32'(in_ready[0]), 32'h1);
        tick();
        drive(0, 1'b1, 8'hA5, 2'd2);
        @(negedge clk);
        check("bp_stall", 32'(in_ready[0]), 32'h0);
        check("bp_hold", 32'(out_data[0][23:16]), 32'h5A);
        tick();
        drive(0, 1'b1, 8'hC3, 2'd1);
        @(negedge clk);
        check("bp_other", 32'(in_ready[0]), 32'h1);
        check("bp_hold2", 32'(out_data[0][23:16]), 32'h5A);
        tick();
        drive(0, 1'b1, 8'hA5, 2'd2);
        out_ready[0] = 4'b1111;
        #1;
        check("bp_comb", 32'(in_ready[0]), 32'h1);
        tick();
        drive(0, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        check("bp_vld2", 32'(out_valid[0][2]), 32'h1);
        check("bp_new", 32'(out_data[0][23:16]), 32'hA5);
        check("bp_lane1", 32'(out_data[0][15:8]), 32'hC3);
        tick();

        // Round robin with a stalled lane 1 on instance 1.
        out_ready[1] = 4'b1101;
        for (int j = 0; j < 4; j++) begin
            drive(1, 1'b1, 8'hE0 + 8'(j), 2'd3);
            tick();
        end
        drive(1, 1'b1, 8'h01, 2'd3);
        tick();
        drive(1, 1'b1, 8'h02, 2'd0);
        @(negedge clk);
        check("rr_lane0", 32'(out_data[1][7:0]), 32'h01);
        check("rr_ptr1", 32'(rr_ptr[1]), 32'h1);
        check("rr_stall", 32'(in_ready[1]), 32'h0);
        tick();
        @(negedge clk);
        check("rr_stall2", 32'(in_ready[1]), 32'h0);
        check("rr_ptr1b", 32'(rr_ptr[1]), 32'h1);
        check("rr_held", 32'(out_data[1][15:8]), 32'hE1);
        tick();
        out_ready[1] = 4'b1111;
        @(negedge clk);
        check("rr_go", 32'(in_ready[1]), 32'h1);
        tick();
        drive(1, 1'b1, 8'h03, 2'd1);
        @(negedge clk);
        check("rr_ptr2", 32'(rr_ptr[1]), 32'h2);
        check("rr_lane1", 32'(out_data[1][15:8]), 32'h02);
        tick();
        drive(1, 1'b1, 8'h04, 2'd2);
        tick();
        drive(1, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        check("rr_lane3", 32'(out_data[1][31:24]), 32'h04);
        check("rr_wrap", 32'(rr_ptr[1]), 32'h0);
        tick();

        // Reset mid-operation: fill all four lanes of instance 1, then reset.
        out_ready[1] = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            drive(1, 1'b1, 8'h90 + 8'(j), 2'd0);
            tick();
        end
        drive(1, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        check("mid_full", 32'(out_valid[1]), 32'hF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_vld", 32'(out_valid[1]), 32'h0);
        check("mid_rr", 32'(rr_ptr[1]), 32'h0);
        tick();
        drive(1, 1'b1, 8'h77, 2'd2);
        tick();
        drive(1, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        check("mid_77v", 32'(out_valid[1]), 32'h1);
        check("mid_77d", 32'(out_data[1][7:0]), 32'h77);
        tick();

        // Random soak on both instances; the scoreboard checks every cycle.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, 1'(($urandom % 4) != 0), 8'($urandom), 2'($urandom));
                out_ready[i] = 4'($urandom) | 4'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 8'h00, 2'd0);
            out_ready[i] = 4'b1111;
        end
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("drained", 32'(out_valid[i]), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer; the inverse of the 4:1 select mux used in the datapath.
- Accepts one WIDTH-bit beat per cycle on a valid/ready input and steers it into one of four output lanes.
- Each output lane has a one-entry holding register with its own valid/ready handshake.
- Lane choice comes either from an explicit 2-bit select or from an internal round-robin pointer.
- Used to fan results or writeback data out to four consumers.

Parameters:
- WIDTH, 8, data width of a beat.
- RR_MODE, 0; 0 = lane taken from in_sel, 1 = in_sel ignored and lane taken from the round-robin pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  input beat.
- in_sel  input  2  target lane (RR_MODE=0 only).
- out_valid  output  4  per-lane beat held, bit k = lane k.
- out_ready  input  4  per-lane consumer accepts, bit k = lane k.
- out_data  output  4*WIDTH  lane k data at bits [k*WIDTH +: WIDTH].
- rr_ptr  output  2  current round-robin lane (always maintained; drives target when RR_MODE=1).

Behaviour:
- **Reset** (rst=1 at a clock edge): out_valid=0000, out_data all zero, rr_ptr=0. Any held beats are discarded. rst wins over all other activity in the same cycle.
- **Target lane:** t = in_sel when RR_MODE=0, t = rr_ptr when RR_MODE=1. in_sel is don't-care while in_valid=0.
- **Lane free:** lane k is free when !out_valid[k] || out_ready[k].
- **in_ready:** in_ready = lane t is free.
  - Purely combinational from out_valid, out_ready and t.
  - Does not depend on in_valid.
  - out_ready -> in_ready is a combinational path by design.
- **Accept:** in_valid && in_ready.
- **Per-lane register update** at each clock edge, per lane k:
  - Accept && t==k: out_data[k] <= in_data, out_valid[k] <= 1. This includes the case where lane k drains in the same cycle: valid stays 1 and new data replaces old with no bubble.
  - Else if out_ready[k]: out_valid[k] <= 0, out_data[k] holds its value.
  - Else: hold.
- **Latency:** a beat accepted at edge N is visible on its lane after edge N (one cycle).
- **Lane independence:** all four lanes drain independently and simultaneously. A stalled lane blocks input only while it is the target.
- **Output stability:** while out_valid[k]=1 and out_ready[k]=0, out_data[k] is stable.
- **No loss or duplication:** beats are never dropped or duplicated. Each accepted beat appears on exactly one lane exactly once.
- **rr_ptr:**
  - Advances by 1 mod 4 (3 -> 0 wrap) only on an accept.
  - Holds on any non-accept cycle, including in_valid=1 with in_ready=0.
  - In RR_MODE=0 it is still maintained the same way (increments on every accept) and serves as a beat-index indicator.
- **Stall in RR mode:** if the pointed-to lane is full and not draining, input stalls even when other lanes are free. There is no skipping.
- **Order:** beats sent to the same lane are delivered in acceptance order.
- **No internal FSM** beyond rr_ptr and the four lane valid flags.

Test Plan:
- **Reset clear:** rst=1 for 2 cycles with in_valid=1, in_data=8'hAA, out_ready=0000 -> out_valid=0000, out_data=0, rr_ptr=0, no lane loads.
- **Explicit steering** (RR_MODE=0, out_ready=1111): send 8'h11 sel0, 8'h22 sel1, 8'h33 sel2, 8'h44 sel3 on consecutive cycles -> each lane shows its value exactly one cycle later for one cycle; in_ready stays 1; rr_ptr ends at 0.
- **Backpressure** (RR_MODE=0): lane 2 out_ready=0; send 8'h5A sel2, then 8'hA5 sel2.
  - in_ready drops to 0 for the second beat and 8'h5A holds stable.
  - Raise out_ready[2] -> in_ready=1 in the same cycle; 8'hA5 replaces 8'h5A with out_valid[2] continuously high.
  - A concurrent beat sel1 is accepted.
- **Round robin with stall** (RR_MODE=1): lanes 0, 2, 3 ready, lane 1 out_ready=0 and already full.
  - Send 8'h01 -> lane 0, rr_ptr=1.
  - 8'h02 stalls (in_ready=0, rr_ptr stays 1) until out_ready[1]=1, then loads lane 1, rr_ptr=2.
  - After 8'h04 lands on lane 3, rr_ptr wraps to 0.
- **Reset mid-operation:** all four lanes full with out_ready=0000; assert rst for 1 cycle -> out_valid=0000, rr_ptr=0. The next beat 8'h77 in RR_MODE=1 lands on lane 0.
- **Random soak:** 10k cycles of random in_valid/in_sel/out_ready -> scoreboard confirms per-lane in-order delivery, no drops or duplicates, out_data stable while stalled.
